// File: rtl/pipeline_stop_ctrl.sv
// pipeline_stop_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Optional statistics counters are built when CTRL_STALL_STATS_EN is defined.
module pipeline_stop_ctrl #(
    parameter int STOP_WIDTH = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_stop_request,
    input  logic                  ex_stop_request,
    input  logic                  ex_multicycle_start,
    input  logic [CNT_WIDTH-1:0]  ex_multicycle_cycles,
    input  logic                  flush_request,
    input  logic [ADDR_WIDTH-1:0] flush_program_counter,
    output logic [STOP_WIDTH-1:0] stop_all,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] new_program_counter,
    output logic                  ex_multicycle_done,
    output logic [1:0]            ctrl_state
`ifdef CTRL_STALL_STATS_EN
    ,
    output logic [31:0]           stall_cycle_count,
    output logic [15:0]           flush_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_EX_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_e;

    // Stall patterns: EX stall freezes PC..EX, ID stall freezes PC..ID.
    localparam logic [STOP_WIDTH-1:0] STOP_NONE = '0;
    localparam logic [STOP_WIDTH-1:0] STOP_EX   = STOP_WIDTH'(4'b1111);
    localparam logic [STOP_WIDTH-1:0] STOP_ID   = STOP_WIDTH'(3'b111);

    state_e                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    flush_q;
    logic [ADDR_WIDTH-1:0]   npc_q;
    logic                    done_q;
    logic [STOP_WIDTH-1:0]   stop_vec;

    logic mc_valid;
    logic mc_single;
    logic mc_long;

    // A zero-length op is a no-op; length one completes without a wait state.
    assign mc_valid  = ex_multicycle_start &&
                       (ex_multicycle_cycles != '0);
    assign mc_single = ex_multicycle_start &&
                       (ex_multicycle_cycles == CNT_WIDTH'(1));
    assign mc_long   = mc_valid && !mc_single;

    // Combinational stall vector; flush and reset always release the pipe.
    always_comb begin
        stop_vec = STOP_NONE;
        if (reset || flush_request || state_q == S_FLUSH) begin
            stop_vec = STOP_NONE;
        end else if (state_q == S_EX_WAIT) begin
            stop_vec = STOP_EX;
        end else if (state_q == S_RUN &&
                     (ex_stop_request || mc_valid)) begin
            stop_vec = STOP_EX;
        end else if (state_q == S_RUN && id_stop_request) begin
            stop_vec = STOP_ID;
        end
    end

    // Sequencer FSM with registered flush, redirect PC and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            npc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            flush_q <= 1'b0;
            unique case (state_q)
                S_RUN: begin
                    if (flush_request) begin
                        npc_q   <= flush_program_counter;
                        flush_q <= 1'b1;
                        state_q <= S_FLUSH;
                    end else if (mc_long) begin
                        cnt_q   <= ex_multicycle_cycles - CNT_WIDTH'(1);
                        state_q <= S_EX_WAIT;
                    end else if (mc_single) begin
                        done_q  <= 1'b1;
                    end
                end
                S_EX_WAIT: begin
                    if (flush_request) begin
                        cnt_q   <= '0;
                        npc_q   <= flush_program_counter;
                        flush_q <= 1'b1;
                        state_q <= S_FLUSH;
                    end else if (cnt_q == CNT_WIDTH'(1)) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        cnt_q   <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_request) begin
                        npc_q   <= flush_program_counter;
                        flush_q <= 1'b1;
                        state_q <= S_FLUSH;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign stop_all            = stop_vec;
    assign flush               = flush_q;
    assign new_program_counter = npc_q;
    assign ex_multicycle_done  = done_q;
    assign ctrl_state          = state_q;

`ifdef CTRL_STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        flush_entry;

    // Re-capture while already flushing is not a new entry.
    assign flush_entry = flush_request &&
                         (state_q == S_RUN || state_q == S_EX_WAIT);

    // Saturating stall-cycle and flush-entry counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stop_vec != STOP_NONE && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_entry && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycle_count = stall_cnt_q;
    assign flush_count       = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stop_ctrl.sv
// tb_pipeline_stop_ctrl: directed test-plan sequences plus random traffic,
// checked against a remaining-stall-cycles reference model.
module tb_pipeline_stop_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        id_stop_request = 1'b0;
    logic        ex_stop_request = 1'b0;
    logic        ex_multicycle_start = 1'b0;
    logic [5:0]  ex_multicycle_cycles = '0;
    logic        flush_request = 1'b0;
    logic [31:0] flush_program_counter = '0;
    logic [5:0]  stop_all;
    logic        flush;
    logic [31:0] new_program_counter;
    logic        ex_multicycle_done;
    logic [1:0]  ctrl_state;
`ifdef CTRL_STALL_STATS_EN
    logic [31:0] stall_cycle_count;
    logic [15:0] flush_count;
`endif

    pipeline_stop_ctrl dut (
        .clock                 (clock),
        .reset                 (reset),
        .id_stop_request       (id_stop_request),
        .ex_stop_request       (ex_stop_request),
        .ex_multicycle_start   (ex_multicycle_start),
        .ex_multicycle_cycles  (ex_multicycle_cycles),
        .flush_request         (flush_request),
        .flush_program_counter (flush_program_counter),
        .stop_all              (stop_all),
        .flush                 (flush),
        .new_program_counter   (new_program_counter),
        .ex_multicycle_done    (ex_multicycle_done),
        .ctrl_state            (ctrl_state)
`ifdef CTRL_STALL_STATS_EN
        ,
        .stall_cycle_count     (stall_cycle_count),
        .flush_count           (flush_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: stall cycles still owed, flush in progress, target.
    int          m_busy = 0;
    bit          m_flushing = 1'b0;
    logic [31:0] m_npc = '0;
    bit          m_done = 1'b0;
    logic [31:0] m_stall = '0;
    logic [15:0] m_fcnt = '0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      tag, got, exp, $time);
    endtask

    task automatic step(input bit r, input bit id, input bit ex,
                        input bit st, input logic [5:0] n,
                        input bit fr, input logic [31:0] pc);
        logic [5:0] exp_stop;
        reset                 = r;
        id_stop_request       = id;
        ex_stop_request       = ex;
        ex_multicycle_start   = st;
        ex_multicycle_cycles  = n;
        flush_request         = fr;
        flush_program_counter = pc;
        #2;
        if (r || fr || m_flushing) exp_stop = 6'h00;
        else if (m_busy > 0 || ex || (st && n != 0)) exp_stop = 6'h0F;
        else if (id) exp_stop = 6'h07;
        else exp_stop = 6'h00;
        chk("stop_all", {26'd0, stop_all}, {26'd0, exp_stop});
        @(posedge clock);
        if (r) begin
            m_stall = '0;
            m_fcnt  = '0;
        end else begin
            if (exp_stop != 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (fr && !m_flushing && m_fcnt != 16'hFFFF) m_fcnt++;
        end
        if (r) begin
            m_busy = 0; m_flushing = 0; m_npc = '0; m_done = 0;
        end else if (fr) begin
            m_flushing = 1; m_npc = pc; m_busy = 0; m_done = 0;
        end else if (m_flushing) begin
            m_flushing = 0; m_done = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            m_done = (m_busy == 0);
        end else if (st && n != 0) begin
            m_busy = int'(n) - 1;
            m_done = (n == 1);
        end else begin
            m_done = 0;
        end
        #1;
        chk("flush", {31'd0, flush}, {31'd0, m_flushing});
        chk("npc", new_program_counter, m_npc);
        chk("done", {31'd0, ex_multicycle_done}, {31'd0, m_done});
        chk("state", {30'd0, ctrl_state},
            m_flushing ? 32'd2 : (m_busy > 0 ? 32'd1 : 32'd0));
`ifdef CTRL_STALL_STATS_EN
        chk("stall_cnt", stall_cycle_count, m_stall);
        chk("flush_cnt", {16'd0, flush_count}, {16'd0, m_fcnt});
`endif
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 6'd0, 0, 32'd0);
    endtask

    initial begin
        step(1, 0, 0, 0, 6'd0, 0, 32'd0);
        step(1, 1, 1, 1, 6'd5, 0, 32'd0);
        idle(1);
        // load-use stall for two cycles
        step(0, 1, 0, 0, 6'd0, 0, 32'd0);
        step(0, 1, 0, 0, 6'd0, 0, 32'd0);
        idle(2);
        // N = 4 multi-cycle op
        step(0, 0, 0, 1, 6'd4, 0, 32'd0);
        idle(6);
        // N = 1 then N = 0
        step(0, 0, 0, 1, 6'd1, 0, 32'd0);
        idle(2);
        step(0, 0, 0, 1, 6'd0, 0, 32'd0);
        idle(2);
        // N = 8 aborted by flush at T+2
        step(0, 0, 0, 1, 6'd8, 0, 32'd0);
        idle(1);
        step(0, 0, 0, 0, 6'd0, 1, 32'h20);
        chk("tp_flush_npc", new_program_counter, 32'h20);
        chk("tp_flush_hi", {31'd0, flush}, 32'd1);
        idle(10);
        // back-to-back flush requests
        step(0, 0, 0, 0, 6'd0, 1, 32'h40);
        step(0, 0, 0, 0, 6'd0, 1, 32'h44);
        chk("tp_flush2_npc", new_program_counter, 32'h44);
        idle(2);
        // reset in the middle of a long op
        step(0, 0, 0, 1, 6'd10, 0, 32'd0);
        idle(2);
        step(1, 0, 0, 0, 6'd0, 0, 32'd0);
        chk("tp_rst_state", {30'd0, ctrl_state}, 32'd0);
        idle(12);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r, id, ex, st, fr;
            logic [5:0]  n;
            logic [31:0] pc;
            r  = ($urandom_range(63) == 0);
            id = ($urandom_range(3) == 0);
            ex = ($urandom_range(7) == 0);
            st = ($urandom_range(5) == 0);
            fr = ($urandom_range(15) == 0);
            n  = 6'($urandom_range(12));
            pc = $urandom & 32'hFFFF_FFFC;
            step(r, id, ex, st, n, fr, pc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
